// File: rtl/axi2per_pkg.sv
// Shared constants and helpers for the AXI-to-peripheral write-response path.
package axi2per_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Packed width of one outstanding-burst record {id, user, len}.
    function automatic int unsigned aw_entry_width(input int unsigned id_w,
                                                   input int unsigned user_w,
                                                   input int unsigned len_w);
        return id_w + user_w + len_w;
    endfunction

endpackage

// File: rtl/axi2per_b_id_fifo.sv
// Pointer-based synchronous FIFO with occupancy counter; holds outstanding AW bursts.
module axi2per_b_id_fifo #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  push_en;
    logic                  pop_en;

    always_comb begin
        full_o   = (cnt_q == CW'(DEPTH));
        empty_o  = (cnt_q == '0);
        data_o   = mem_q[rd_ptr_q];
        push_en  = push_i && !full_o;
        pop_en   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/axi2per_b_resp_gen.sv
// Tracks peripheral beat completions against queued AW bursts and emits one
// AXI B response per burst through a single-entry output register.
module axi2per_b_resp_gen
    import axi2per_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 6,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [USER_WIDTH-1:0] aw_user_i,
    input  logic [LEN_WIDTH-1:0]  aw_len_i,
    output logic                  aw_ready_o,
    input  logic                  wr_rsp_valid_i,
    input  logic                  wr_rsp_err_i,
    output logic                  wr_rsp_ready_o,
    output logic                  b_valid_o,
    output logic [1:0]            b_resp_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [USER_WIDTH-1:0] b_user_o,
    input  logic                  b_ready_i
);
    // Handshakes: a transfer happens on a cycle where valid && ready at the
    // rising edge; a producer holding valid keeps its payload stable until then.

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [USER_WIDTH-1:0] user;
        logic [LEN_WIDTH-1:0]  len;
    } aw_entry_t;

    localparam int unsigned EW = aw_entry_width(ID_WIDTH, USER_WIDTH, LEN_WIDTH);

    aw_entry_t             push_entry;
    aw_entry_t             head;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic                  last, slot_free, beat_acc, last_acc;

    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic                  b_valid_q, b_valid_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [USER_WIDTH-1:0] b_user_q, b_user_d;

    axi2per_b_id_fifo #(
        .DATA_WIDTH (EW),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        push_entry = '{id: aw_id_i, user: aw_user_i, len: aw_len_i};
        aw_ready_o = !fifo_full;
        push       = aw_valid_i && !fifo_full;
        last       = (beat_cnt_q == head.len);
        // A last beat may only complete when the output register can take it.
        slot_free      = !b_valid_q || b_ready_i;
        wr_rsp_ready_o = !fifo_empty && (!last || slot_free);
        beat_acc       = wr_rsp_valid_i && wr_rsp_ready_o;
        last_acc       = beat_acc && last;
        pop            = last_acc;
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        b_id_d     = b_id_q;
        b_user_d   = b_user_q;
        if (last_acc) begin
            beat_cnt_d = '0;
            err_d      = 1'b0;
            b_valid_d  = 1'b1;
            b_id_d     = head.id;
            b_user_d   = head.user;
            b_resp_d   = (err_q || wr_rsp_err_i) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else begin
            if (beat_acc) begin
                beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                err_d      = err_q || wr_rsp_err_i;
            end
            if (b_ready_i) begin
                b_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
            b_id_q     <= '0;
            b_user_q   <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            b_id_q     <= b_id_d;
            b_user_q   <= b_user_d;
        end
    end

    assign b_valid_o = b_valid_q;
    assign b_resp_o  = b_resp_q;
    assign b_id_o    = b_id_q;
    assign b_user_o  = b_user_q;

endmodule

// File: tb/tb_axi2per_b_resp_gen.sv
// Bench for axi2per_b_resp_gen: directed vector table, hand-written corner
// sequences and random traffic, all checked against a burst-queue model.
module tb_axi2per_b_resp_gen;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       aw_valid;
    logic [3:0] aw_id;
    logic [5:0] aw_user;
    logic [7:0] aw_len;
    logic       aw_ready_o;
    logic       wr_rsp_valid;
    logic       wr_rsp_err;
    logic       wr_rsp_ready_o;
    logic       b_valid_o;
    logic [1:0] b_resp_o;
    logic [3:0] b_id_o;
    logic [5:0] b_user_o;
    logic       b_ready;

    axi2per_b_resp_gen #(
        .ID_WIDTH   (4),
        .USER_WIDTH (6),
        .LEN_WIDTH  (8),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .aw_valid_i     (aw_valid),
        .aw_id_i        (aw_id),
        .aw_user_i      (aw_user),
        .aw_len_i       (aw_len),
        .aw_ready_o     (aw_ready_o),
        .wr_rsp_valid_i (wr_rsp_valid),
        .wr_rsp_err_i   (wr_rsp_err),
        .wr_rsp_ready_o (wr_rsp_ready_o),
        .b_valid_o      (b_valid_o),
        .b_resp_o       (b_resp_o),
        .b_id_o         (b_id_o),
        .b_user_o       (b_user_o),
        .b_ready_i      (b_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] id;
        logic [5:0] user;
        logic [7:0] len;
    } burst_t;

    burst_t      m_q[$];
    int          m_cnt;
    logic        m_err;
    logic        mb_valid;
    logic [1:0]  mb_resp;
    logic [3:0]  mb_id;
    logic [5:0]  mb_user;
    logic [11:0] exp_q[$];
    logic [3:0]  got_ids[$];

    int n_checks;
    int n_fail;

    logic       s_aw_rdy, s_wr_rdy, s_bv;
    logic [1:0] s_resp;
    logic [3:0] s_id;
    logic [5:0] s_user;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_cnt    = 0;
        m_err    = 1'b0;
        mb_valid = 1'b0;
        mb_resp  = 2'b00;
        mb_id    = 4'd0;
        mb_user  = 6'd0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called #1 after a rising edge; samples outputs at the falling edge.
    task automatic step(input logic awv, input logic [3:0] id, input logic [5:0] user,
                        input logic [7:0] len, input logic wv, input logic we,
                        input logic br);
        int          n;
        logic        e_aw, e_last, e_wr, acc;
        logic [11:0] e;
        burst_t      hd;
        aw_valid     = awv;
        aw_id        = id;
        aw_user      = user;
        aw_len       = len;
        wr_rsp_valid = wv;
        wr_rsp_err   = we;
        b_ready      = br;
        #4;
        n      = m_q.size();
        e_aw   = (n < DEPTH);
        e_last = 1'b0;
        hd     = '{id: 4'd0, user: 6'd0, len: 8'd0};
        if (n > 0) begin
            hd     = m_q[0];
            e_last = (m_cnt == int'(hd.len));
        end
        e_wr = (n > 0) && (!e_last || !mb_valid || br);

        s_aw_rdy = aw_ready_o;
        s_wr_rdy = wr_rsp_ready_o;
        s_bv     = b_valid_o;
        s_resp   = b_resp_o;
        s_id     = b_id_o;
        s_user   = b_user_o;

        chk("mdl_aw_ready", 32'(aw_ready_o), 32'(e_aw));
        chk("mdl_wr_ready", 32'(wr_rsp_ready_o), 32'(e_wr));
        chk("mdl_b_valid", 32'(b_valid_o), 32'(mb_valid));
        chk("mdl_b_payload", 32'({b_id_o, b_user_o, b_resp_o}), 32'({mb_id, mb_user, mb_resp}));

        // scoreboard: every observed B handshake must match the oldest expected response
        if (b_valid_o && br) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_b: got id %0h expected none", b_id_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_b_beat", 32'({b_id_o, b_user_o, b_resp_o}), 32'(e));
                got_ids.push_back(b_id_o);
            end
        end

        acc = wv && e_wr;
        if (acc && e_last) begin
            mb_valid = 1'b1;
            mb_id    = hd.id;
            mb_user  = hd.user;
            mb_resp  = (m_err || we) ? 2'b10 : 2'b00;
            exp_q.push_back({mb_id, mb_user, mb_resp});
            void'(m_q.pop_front());
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (acc) begin
                m_cnt++;
                m_err = m_err || we;
            end
            if (br) mb_valid = 1'b0;
        end
        if (awv && e_aw) m_q.push_back('{id: id, user: user, len: len});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic br);
        step(1'b0, 4'd0, 6'd0, 8'd0, 1'b0, 1'b0, br);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       awv;
        logic [3:0] id;
        logic [5:0] user;
        logic [7:0] len;
        logic       wv;
        logic       we;
        logic       br;
        logic       e_aw;
        logic       e_wr;
        logic       e_bv;
        logic [1:0] e_resp;
        logic [3:0] e_id;
        logic [5:0] e_user;
    } vec_t;

    vec_t vt[16];

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        aw_valid     = 1'b0;
        aw_id        = 4'd0;
        aw_user      = 6'd0;
        aw_len       = 8'd0;
        wr_rsp_valid = 1'b0;
        wr_rsp_err   = 1'b0;
        b_ready      = 1'b0;
        model_reset();

        // single beat, OKAY
        vt[0]  = '{1'b1, 4'd3, 6'h15, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[1]  = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[2]  = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'd3, 6'h15};
        vt[3]  = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 6'h00};
        // len=3 burst, error on beat 2
        vt[4]  = '{1'b1, 4'd5, 6'h2A, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[5]  = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[6]  = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[7]  = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[8]  = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[9]  = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 6'h2A};
        vt[10] = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 6'h00};
        // beat offered to an empty queue, then a burst arrives
        vt[11] = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[12] = '{1'b1, 4'd7, 6'h01, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[13] = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'd0, 6'h00};
        vt[14] = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'd7, 6'h01};
        vt[15] = '{1'b0, 4'd0, 6'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 6'h00};

        // reset values while reset is held
        #2;
        chk("rst_b_valid", 32'(b_valid_o), 32'd0);
        chk("rst_b_payload", 32'({b_id_o, b_user_o, b_resp_o}), 32'd0);
        chk("rst_aw_ready", 32'(aw_ready_o), 32'd1);
        chk("rst_wr_ready", 32'(wr_rsp_ready_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vt[i].awv, vt[i].id, vt[i].user, vt[i].len, vt[i].wv, vt[i].we, vt[i].br);
            chk($sformatf("vec%0d_aw_ready", i), 32'(s_aw_rdy), 32'(vt[i].e_aw));
            chk($sformatf("vec%0d_wr_ready", i), 32'(s_wr_rdy), 32'(vt[i].e_wr));
            chk($sformatf("vec%0d_b_valid", i), 32'(s_bv), 32'(vt[i].e_bv));
            if (vt[i].e_bv) begin
                chk($sformatf("vec%0d_b_payload", i), 32'({s_id, s_user, s_resp}),
                    32'({vt[i].e_id, vt[i].e_user, vt[i].e_resp}));
            end
        end

        // fill to DEPTH, refuse a 5th push, then backpressure the B side
        got_ids.delete();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 4'(i), 6'(i * 5), 8'd0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 4'd9, 6'h3F, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("fill_aw_ready_full", 32'(s_aw_rdy), 32'd0);
        step(1'b0, 4'd0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_first_beat_ready", 32'(s_wr_rdy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'd0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b0);
            chk("bp_hold_valid", 32'(s_bv), 32'd1);
            chk("bp_hold_id", 32'(s_id), 32'd1);
            chk("bp_last_beat_blocked", 32'(s_wr_rdy), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'd0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        end
        idle(1'b1);
        chk("order_count", 32'(got_ids.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_ids.size()) chk("order_id", 32'(got_ids[k]), 32'(k + 1));
        end

        // back-to-back responses with no bubble
        step(1'b1, 4'd10, 6'd3, 8'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd11, 6'd4, 8'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'd0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        chk("b2b_first_valid", 32'(s_bv), 32'd1);
        chk("b2b_first_id", 32'(s_id), 32'd10);
        idle(1'b1);
        chk("b2b_second_valid", 32'(s_bv), 32'd1);
        chk("b2b_second_id", 32'(s_id), 32'd11);
        idle(1'b1);
        chk("b2b_done_valid", 32'(s_bv), 32'd0);

        // asynchronous reset in the middle of a burst
        step(1'b1, 4'd6, 6'd9, 8'd3, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'd0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_b_valid", 32'(b_valid_o), 32'd0);
        chk("mid_rst_b_payload", 32'({b_id_o, b_user_o, b_resp_o}), 32'd0);
        chk("mid_rst_aw_ready", 32'(aw_ready_o), 32'd1);
        chk("mid_rst_wr_ready", 32'(wr_rsp_ready_o), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'd0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b1);
            chk("post_rst_no_b", 32'(s_bv), 32'd0);
        end
        chk("post_rst_aw_ready", 32'(s_aw_rdy), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom),
                 8'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 4'd0, 6'd0, 8'd0, 1'b1, 1'b0, 1'b1);
        end
        chk("drain_exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_queue_empty", 32'(m_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
